// File: rtl/k_fifo2_arb_ctrl.sv
// Controller for a 2-entry dual-port FIFO RAM: round-robin merge of two
// producers into the RAM, pointer/occupancy tracking and a consumer port.
module k_fifo2_arb_ctrl #(
    parameter int data_size = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in0_valid,
    input  logic [data_size-1:0] in0_data,
    output logic                 in0_ready,
    input  logic                 in1_valid,
    input  logic [data_size-1:0] in1_data,
    output logic                 in1_ready,
    output logic                 out_valid,
    output logic [data_size-1:0] out_data,
    input  logic                 out_ready,
    output logic                 ram_wen,
    output logic                 ram_waddr,
    output logic                 ram_raddr,
    output logic [data_size-1:0] ram_d,
    input  logic [data_size-1:0] ram_q,
    output logic [1:0]           count,
    output logic                 full,
    output logic                 empty
);

    // Handshake: a transfer happens on the rising edge where valid and ready
    // are both high; ready may look at valid, valid never looks at ready.

    logic wptr;
    logic rptr;
    logic last;
    logic grant_valid;
    logic grant_idx;
    logic can_push;
    logic push;
    logic pop;

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

    // Round robin: on contention the producer not granted last time wins.
    always_comb begin
        grant_valid = in0_valid | in1_valid;
        grant_idx   = (in0_valid && in1_valid) ? ~last : in1_valid;
    end

    // Readies are held low while reset is asserted, whatever the producers do.
    assign can_push  = rst_n && !full;
    assign push      = can_push && grant_valid;
    assign in0_ready = can_push && grant_valid && !grant_idx;
    assign in1_ready = can_push && grant_valid && grant_idx;

    assign ram_wen   = push;
    assign ram_waddr = wptr;
    assign ram_d     = grant_idx ? in1_data : in0_data;

    assign out_valid = !empty;
    assign ram_raddr = rptr;
    assign out_data  = ram_q;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
            last  <= 1'b1;
        end else begin
            if (push) begin
                wptr <= ~wptr;
                last <= grant_idx;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule
